triangle_checker: RTL and testbench

Consumer-side monitor for N-bit triangle-wave sample streams: accepts one sample per enabled cycle, locks onto the ramp direction, flags peaks and troughs, measures the period in samples and reports any step that is not a legal ±1 ramp move. It sits downstream of the etch-a-sketch waveform sources, both as an on-chip sanity monitor and as the checking half of generator benches.

---
 rtl/triangle_pkg.sv | 18 +
 rtl/triangle_checker_sat_counter.sv | 23 ++
 rtl/triangle_checker.sv | 167 ++++++++++++++++
 tb/tb_triangle_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/triangle_pkg.sv
// Shared types and ramp constants for the triangle-wave generators and checker.
package triangle_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } triangle_chk_state_t;

  localparam int unsigned ERR_COUNT_W = 16;

  // Top of the ramp for an n-bit sample: 2^n - 1.
  function automatic logic [31:0] ramp_max(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/triangle_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count register: reset/clear to zero, otherwise increment until all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/triangle_checker.sv
// Triangle-wave stream monitor: locks onto ramp direction, flags peaks and
// troughs, measures trough-to-trough period and pulses err on illegal steps.
// Optional: define TRIANGLE_CHECKER_ERRCNT_EN to add a saturating err_count output.
module triangle_checker
  import triangle_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] in,
  output logic         locked,
  output logic         dir,
  output logic         at_peak,
  output logic         at_trough,
  output logic [N:0]   period,
  output logic         period_valid,
  output logic         err
`ifdef TRIANGLE_CHECKER_ERRCNT_EN
  ,
  output logic [ERR_COUNT_W-1:0] err_count
`endif
);

  localparam int unsigned   CW       = N + 1;
  localparam logic [N-1:0]  RAMP_MAX = N'(ramp_max(N));
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  triangle_chk_state_t state_q, state_d;
  logic [N-1:0]  prev_q, prev_d;
  logic          first_q, first_d;
  logic          locked_q, locked_d;
  logic          dir_q, dir_d;
  logic          peak_q, peak_d;
  logic          trough_q, trough_d;
  logic          pv_q, pv_d;
  logic          err_q, err_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] cnt_q;
  logic          cnt_inc, cnt_clr;

  logic [CW-1:0] in_ext, prev_ext;
  logic          up_step, dn_step, up_ok, dn_ok;

  // Step comparisons are done one bit wider so 0 <-> max never looks legal.
  assign in_ext   = CW'(in);
  assign prev_ext = CW'(prev_q);
  assign up_step  = (in_ext == prev_ext + CW'(1));
  assign dn_step  = (in_ext + CW'(1) == prev_ext);
  assign up_ok    = up_step && ((state_q == ARMED) || (state_q == UP));
  assign dn_ok    = dn_step && ((state_q == ARMED) || (state_q == DOWN));

  // Next-state, pulse and period-counter control for each accepted sample.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    first_d  = first_q;
    dir_d    = dir_q;
    period_d = period_q;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    if (ena) begin
      prev_d = in;
      case (state_q)
        SYNC: begin
          state_d = ARMED;
          cnt_clr = 1'b1;
          first_d = 1'b0;
        end
        ARMED, UP, DOWN: begin
          if (up_ok) begin
            cnt_inc = 1'b1;
            if (in == RAMP_MAX) begin
              peak_d  = 1'b1;
              state_d = DOWN;
              dir_d   = 1'b1;
            end else begin
              state_d = UP;
              dir_d   = 1'b0;
            end
          end else if (dn_ok) begin
            if (in == '0) begin
              trough_d = 1'b1;
              state_d  = UP;
              dir_d    = 1'b0;
              cnt_clr  = 1'b1;
              first_d  = 1'b1;
              if (first_q) begin
                pv_d     = 1'b1;
                period_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
              end
            end else begin
              cnt_inc = 1'b1;
              state_d = DOWN;
              dir_d   = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ARMED;
            cnt_clr = 1'b1;
            first_d = 1'b0;
          end
        end
      endcase
    end
    locked_d = (state_d == UP) || (state_d == DOWN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SYNC;
      prev_q   <= '0;
      first_q  <= 1'b0;
      locked_q <= 1'b0;
      dir_q    <= 1'b0;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      first_q  <= first_d;
      locked_q <= locked_d;
      dir_q    <= dir_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
      period_q <= period_d;
    end
  end

  sat_counter #(.W(CW)) u_period_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .q   (cnt_q)
  );

`ifdef TRIANGLE_CHECKER_ERRCNT_EN
  sat_counter #(.W(ERR_COUNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_d),
    .clr (1'b0),
    .q   (err_count)
  );
`endif

  assign locked       = locked_q;
  assign dir          = dir_q;
  assign at_peak      = peak_q;
  assign at_trough    = trough_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign err          = err_q;

endmodule

// File: tb/tb_triangle_checker.sv
// Scoreboard bench for triangle_checker (N=4): driver pushes model predictions,
// monitor pops and compares one prediction per clock.
module tb_triangle_checker;

  localparam int NW   = 4;
  localparam int MAXV = (1 << NW) - 1;

  logic          clk;
  logic          rst;
  logic          ena;
  logic [NW-1:0] smp;
  logic          locked, dir, at_peak, at_trough, period_valid, err;
  logic [NW:0]   period;
`ifdef TRIANGLE_CHECKER_ERRCNT_EN
  logic [15:0]   err_count;
`endif

  triangle_checker #(.N(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .in           (smp),
    .locked       (locked),
    .dir          (dir),
    .at_peak      (at_peak),
    .at_trough    (at_trough),
    .period       (period),
    .period_valid (period_valid),
    .err          (err)
`ifdef TRIANGLE_CHECKER_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit dir;
    bit peak;
    bit trough;
    int period;
    bit pv;
    bit err;
    int errcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: phase 0 = nothing seen, 1 = one sample held, 2 = locked.
  int m_phase = 0;
  int m_prev = 0;
  bit m_down = 0;
  bit m_first = 0;
  int m_idx = 0;
  int m_last = 0;
  int m_period = 0;
  int m_errcnt = 0;

  function automatic exp_t model_step(input bit r, input bit e, input int v);
    exp_t x;
    bit up_ok;
    bit dn_ok;
    x.peak = 0; x.trough = 0; x.pv = 0; x.err = 0;
    if (r) begin
      m_phase = 0; m_prev = 0; m_down = 0; m_first = 0;
      m_idx = 0; m_last = 0; m_period = 0; m_errcnt = 0;
    end else if (e) begin
      up_ok = (m_phase == 1 || (m_phase == 2 && !m_down)) && (v == m_prev + 1);
      dn_ok = (m_phase == 1 || (m_phase == 2 && m_down)) && (v == m_prev - 1);
      if (m_phase == 0) begin
        m_phase = 1;
        m_first = 0;
      end else if (up_ok || dn_ok) begin
        m_phase = 2;
        m_idx++;
        if (up_ok) begin
          m_down = (v == MAXV);
          x.peak = (v == MAXV);
        end else begin
          m_down = (v != 0);
          if (v == 0) begin
            x.trough = 1;
            if (m_first) begin
              m_period = m_idx - m_last;
              if (m_period > 2 * MAXV + 1) m_period = 2 * MAXV + 1;
              x.pv = 1;
            end
            m_first = 1;
            m_last = m_idx;
          end
        end
      end else begin
        x.err = 1;
        m_phase = 1;
        m_first = 0;
        if (m_errcnt < 65535) m_errcnt++;
      end
      m_prev = v;
    end
    x.locked = (m_phase == 2);
    x.dir    = m_down;
    x.period = m_period;
    x.errcnt = m_errcnt;
    return x;
  endfunction

  task automatic drive(input bit r, input bit e, input int v);
    @(negedge clk);
    rst = r;
    ena = e;
    smp = NW'(v);
    exp_q.push_back(model_step(r, e, v));
  endtask

  task automatic send(input int v);
    drive(1'b0, 1'b1, v);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, MAXV)));
    drive(1'b1, 1'b0, 0);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("locked", int'(locked), int'(x.locked));
        if (x.locked) chk("dir", int'(dir), int'(x.dir));
        chk("at_peak", int'(at_peak), int'(x.peak));
        chk("at_trough", int'(at_trough), int'(x.trough));
        chk("period", int'(period), x.period);
        chk("period_valid", int'(period_valid), int'(x.pv));
        chk("err", int'(err), int'(x.err));
`ifdef TRIANGLE_CHECKER_ERRCNT_EN
        chk("err_count", int'(err_count), x.errcnt);
`endif
      end
    end
  end

  // Stimulus
  initial begin
    int g;
    bit g_up;
    int r;
    rst = 1'b1;
    ena = 1'b0;
    smp = '0;
    do_reset();

    // Ideal ramp, ena every cycle: two full periods.
    for (int k = 0; k < 2; k++) begin
      for (int v = 0; v <= MAXV; v++) send(v);
      for (int v = MAXV - 1; v >= 0; v--) send(v);
    end
    send(1);

    // Same ramp with ena toggling.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int v = 0; v <= MAXV; v++) begin
        send(v);
        drive(1'b0, 1'b0, int'($urandom_range(0, MAXV)));
      end
      for (int v = MAXV - 1; v >= 0; v--) begin
        send(v);
        drive(1'b0, 1'b0, int'($urandom_range(0, MAXV)));
      end
    end

    // Mid-ramp start going down; first trough only arms the period.
    do_reset();
    for (int v = 9; v >= 0; v--) send(v);
    for (int v = 1; v <= 5; v++) send(v);

    // Bad step while UP, then relock.
    send(6); send(8); send(9); send(10);

    // Wrap and repeated-value errors.
    for (int v = 11; v <= MAXV; v++) send(v);
    send(0);
    send(6); send(7); send(7);

    // Reset in the middle of a down ramp, then relock down.
    do_reset();
    for (int v = 10; v >= 5; v--) send(v);
    do_reset();
    send(3); send(2); send(1); send(0);

    // Randomized: mostly legal ramp with gaps, glitches and resets.
    g = 0;
    g_up = 1;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, MAXV)));
      end else if (r < 20) begin
        drive(1'b0, 1'b0, int'($urandom_range(0, MAXV)));
      end else if (r < 25) begin
        g = int'($urandom_range(0, MAXV));
        send(g);
      end else begin
        if (g_up) begin
          if (g >= MAXV) begin g_up = 0; g = MAXV - 1; end
          else g++;
        end else begin
          if (g <= 0) begin g_up = 1; g = 1; end
          else g--;
        end
        send(g);
      end
    end

    drive(1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
